// File: rtl/blk_mem_pkg.sv
// ---------------------------------------------------------------------------
// blk_mem_pkg
// Shared definitions for the main-memory block-port arbiter:
//   - arb_state_t          : arbiter FSM states
//   - BLOCK_W_DEFAULT      : default cache block width in bits
//   - OFFSET_BITS_DEFAULT  : default number of block-offset address bits
//   - block_align()        : clears the block-offset bits of an address
// ---------------------------------------------------------------------------
package blk_mem_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        DONE = 3'd4
    } arb_state_t;

    localparam int BLOCK_W_DEFAULT     = 256;
    localparam int OFFSET_BITS_DEFAULT = 5;

    // Widest address the helper handles; callers cast to their own width.
    localparam int ALIGN_MAX_W = 64;

    function automatic logic [ALIGN_MAX_W-1:0] block_align(
        input logic [ALIGN_MAX_W-1:0] addr,
        input int unsigned            offset_bits
    );
        logic [ALIGN_MAX_W-1:0] mask;
        mask = '1;
        mask = mask << offset_bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/blk_arb_priority.sv
// ---------------------------------------------------------------------------
// blk_arb_priority
// Winner select for the block port plus the I-side anti-starvation counter.
// D-side normally wins; once STARVE_LIMIT consecutive D grants have been made
// while I was eligible, the next contested grant goes to I.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   arb_en         1 while the arbiter is IDLE and may grant
//   i_req, d_req   request levels from I-side and D-side
//   drain          1 = I-side is not eligible for new grants
//   grant_i        I-side wins this cycle (combinational)
//   grant_d        D-side wins this cycle (combinational)
// ---------------------------------------------------------------------------
module blk_arb_priority #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    input  logic i_req,
    input  logic d_req,
    input  logic drain,
    output logic grant_i,
    output logic grant_d
);

    // At least two bits so the counter can always represent the limit.
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 2) ? $clog2(STARVE_LIMIT + 1) : 2;

    logic [CNT_W-1:0] starve_cnt;
    logic             i_eligible;
    logic             i_forced;

    always_comb begin
        i_eligible = i_req & ~drain;
        i_forced   = (starve_cnt >= CNT_W'(STARVE_LIMIT));
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        if (arb_en) begin
            if (d_req && i_eligible) begin
                grant_i = i_forced;
                grant_d = ~i_forced;
            end else begin
                grant_d = d_req;
                grant_i = i_eligible;
            end
        end
    end

    // Counts D grants that were made over a waiting I request; saturates at
    // the limit and is untouched by grants made while I is not eligible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && i_eligible && (starve_cnt < CNT_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/blk_mem_arbiter.sv
// ---------------------------------------------------------------------------
// blk_mem_arbiter
// Shares the single main-memory block-transfer port between the I-side block
// reader and the D-side block reader/writer. One request is latched at a
// time, the memory strobe is held until the matching valid, then data and a
// one-cycle ack go back to the winner, followed by a one-cycle DONE gap.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req, i_addr              I-side block read request / address
//   i_rblock, i_ack            I-side returned block / completion pulse
//   d_req, d_we, d_addr        D-side request, write enable, address
//   d_wblock                   D-side write block
//   d_rblock, d_ack            D-side returned block / completion pulse
//   drain                      1 = grant no new I requests
//   mem_addr                   block-aligned address to memory
//   mem_blk_read/_write        registered memory strobes
//   mem_wblock, mem_rblock     write block to / read block from memory
//   mem_read_valid/_write_valid memory completion indications
//   busy                       arbiter not IDLE
//   drained                    drain high, IDLE and no D request pending
// ---------------------------------------------------------------------------
module blk_mem_arbiter
    import blk_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int BLOCK_W      = BLOCK_W_DEFAULT,
    parameter int OFFSET_BITS  = OFFSET_BITS_DEFAULT,
    parameter int STARVE_LIMIT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [BLOCK_W-1:0] i_rblock,
    output logic               i_ack,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [BLOCK_W-1:0] d_wblock,
    output logic [BLOCK_W-1:0] d_rblock,
    output logic               d_ack,
    input  logic               drain,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_blk_read,
    output logic               mem_blk_write,
    output logic [BLOCK_W-1:0] mem_wblock,
    input  logic [BLOCK_W-1:0] mem_rblock,
    input  logic               mem_read_valid,
    input  logic               mem_write_valid,
    output logic               busy,
    output logic               drained
);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic               grant_i;
    logic               grant_d;
    logic [ADDR_W-1:0]  i_addr_aligned;
    logic [ADDR_W-1:0]  d_addr_aligned;
    logic [ADDR_W-1:0]  mem_addr_nxt;
    logic [BLOCK_W-1:0] mem_wblock_nxt;
    logic [BLOCK_W-1:0] i_rblock_nxt;
    logic [BLOCK_W-1:0] d_rblock_nxt;
    logic               i_ack_nxt;
    logic               d_ack_nxt;
    logic               rd_strobe_nxt;
    logic               wr_strobe_nxt;

    blk_arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_priority (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb_en  (state == IDLE),
        .i_req   (i_req),
        .d_req   (d_req),
        .drain   (drain),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    assign i_addr_aligned = ADDR_W'(block_align(ALIGN_MAX_W'(i_addr), OFFSET_BITS));
    assign d_addr_aligned = ADDR_W'(block_align(ALIGN_MAX_W'(d_addr), OFFSET_BITS));

    // Next-state and datapath-next logic. Request fields are only looked at
    // in IDLE on the grant cycle; afterwards the latched copies are used.
    // Strobes are derived from the next state so they are registered and
    // drop on the same edge that captures the completing valid.
    always_comb begin
        state_nxt      = state;
        mem_addr_nxt   = mem_addr;
        mem_wblock_nxt = mem_wblock;
        i_rblock_nxt   = i_rblock;
        d_rblock_nxt   = d_rblock;
        i_ack_nxt      = 1'b0;
        d_ack_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    mem_addr_nxt = d_addr_aligned;
                    if (d_we) begin
                        mem_wblock_nxt = d_wblock;
                        state_nxt      = D_WR;
                    end else begin
                        state_nxt = D_RD;
                    end
                end else if (grant_i) begin
                    mem_addr_nxt = i_addr_aligned;
                    state_nxt    = I_RD;
                end
            end
            I_RD: begin
                if (mem_read_valid) begin
                    i_rblock_nxt = mem_rblock;
                    i_ack_nxt    = 1'b1;
                    state_nxt    = DONE;
                end
            end
            D_RD: begin
                if (mem_read_valid) begin
                    d_rblock_nxt = mem_rblock;
                    d_ack_nxt    = 1'b1;
                    state_nxt    = DONE;
                end
            end
            D_WR: begin
                if (mem_write_valid) begin
                    d_ack_nxt = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        rd_strobe_nxt = (state_nxt == I_RD) || (state_nxt == D_RD);
        wr_strobe_nxt = (state_nxt == D_WR);
    end

    // State and output registers. Reset abandons any transfer in flight, so
    // strobes drop asynchronously and no ack is ever produced for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mem_addr      <= '0;
            mem_wblock    <= '0;
            i_rblock      <= '0;
            d_rblock      <= '0;
            i_ack         <= 1'b0;
            d_ack         <= 1'b0;
            mem_blk_read  <= 1'b0;
            mem_blk_write <= 1'b0;
        end else begin
            state         <= state_nxt;
            mem_addr      <= mem_addr_nxt;
            mem_wblock    <= mem_wblock_nxt;
            i_rblock      <= i_rblock_nxt;
            d_rblock      <= d_rblock_nxt;
            i_ack         <= i_ack_nxt;
            d_ack         <= d_ack_nxt;
            mem_blk_read  <= rd_strobe_nxt;
            mem_blk_write <= wr_strobe_nxt;
        end
    end

    assign busy    = (state != IDLE);
    assign drained = drain && (state == IDLE) && !d_req;

endmodule

// File: tb/tb_blk_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_blk_mem_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level
// model of the arbiter (current owner, pending-gap flag, starvation count)
// advances on every clock edge from the same inputs the DUT sees, and a
// compare process checks every DUT output against it on each falling edge.
// ---------------------------------------------------------------------------
module tb_blk_mem_arbiter;

    localparam int ADDR_W       = 32;
    localparam int BLOCK_W      = 256;
    localparam int STARVE_LIMIT = 3;
    localparam logic [31:0] OFF_MASK = 32'h0000_001F;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_req;
    logic [ADDR_W-1:0]  i_addr;
    logic [BLOCK_W-1:0] i_rblock;
    logic               i_ack;
    logic               d_req;
    logic               d_we;
    logic [ADDR_W-1:0]  d_addr;
    logic [BLOCK_W-1:0] d_wblock;
    logic [BLOCK_W-1:0] d_rblock;
    logic               d_ack;
    logic               drain;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_blk_read;
    logic               mem_blk_write;
    logic [BLOCK_W-1:0] mem_wblock;
    logic [BLOCK_W-1:0] mem_rblock;
    logic               mem_read_valid;
    logic               mem_write_valid;
    logic               busy;
    logic               drained;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Transaction-level model: owner 0 = none, 1 = I-side, 2 = D-side.
    int                 m_owner  = 0;
    bit                 m_wr     = 1'b0;
    bit                 m_done   = 1'b0;
    int                 m_starve = 0;
    logic [ADDR_W-1:0]  m_addr   = '0;
    logic [BLOCK_W-1:0] m_wblock = '0;
    logic [BLOCK_W-1:0] e_irb    = '0;
    logic [BLOCK_W-1:0] e_drb    = '0;
    bit                 e_iack   = 1'b0;
    bit                 e_dack   = 1'b0;

    int exp_order[8] = '{2, 2, 2, 1, 2, 2, 2, 1};
    int got_order[8];

    always #5 clk = ~clk;

    blk_mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .BLOCK_W      (BLOCK_W),
        .OFFSET_BITS  (5),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_req           (i_req),
        .i_addr          (i_addr),
        .i_rblock        (i_rblock),
        .i_ack           (i_ack),
        .d_req           (d_req),
        .d_we            (d_we),
        .d_addr          (d_addr),
        .d_wblock        (d_wblock),
        .d_rblock        (d_rblock),
        .d_ack           (d_ack),
        .drain           (drain),
        .mem_addr        (mem_addr),
        .mem_blk_read    (mem_blk_read),
        .mem_blk_write   (mem_blk_write),
        .mem_wblock      (mem_wblock),
        .mem_rblock      (mem_rblock),
        .mem_read_valid  (mem_read_valid),
        .mem_write_valid (mem_write_valid),
        .busy            (busy),
        .drained         (drained)
    );

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                 input logic dwe, input logic [31:0] da,
                                 input logic [255:0] dwb, input logic dn);
        i_req    = ir;
        i_addr   = ia;
        d_req    = dr;
        d_we     = dwe;
        d_addr   = da;
        d_wblock = dwb;
        drain    = dn;
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    function automatic logic [255:0] randBlock();
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[k*32 +: 32] = $urandom();
        return b;
    endfunction

    // Reference model: one transfer at a time, D preferred unless the
    // starvation count has reached the limit while I is eligible.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner  <= 0;
            m_wr     <= 1'b0;
            m_done   <= 1'b0;
            m_starve <= 0;
            m_addr   <= '0;
            m_wblock <= '0;
            e_irb    <= '0;
            e_drb    <= '0;
            e_iack   <= 1'b0;
            e_dack   <= 1'b0;
        end else begin
            e_iack <= 1'b0;
            e_dack <= 1'b0;
            if (m_done) begin
                m_done <= 1'b0;
            end else if (m_owner == 0) begin
                if (d_req && !(i_req && !drain && m_starve >= STARVE_LIMIT)) begin
                    m_owner <= 2;
                    m_wr    <= d_we;
                    m_addr  <= d_addr & ~OFF_MASK;
                    if (d_we) m_wblock <= d_wblock;
                    if (i_req && !drain && m_starve < STARVE_LIMIT) m_starve <= m_starve + 1;
                end else if (i_req && !drain) begin
                    m_owner  <= 1;
                    m_wr     <= 1'b0;
                    m_addr   <= i_addr & ~OFF_MASK;
                    m_starve <= 0;
                end
            end else if (m_wr ? mem_write_valid : mem_read_valid) begin
                if (!m_wr && m_owner == 1) e_irb <= mem_rblock;
                if (!m_wr && m_owner == 2) e_drb <= mem_rblock;
                if (m_owner == 1) e_iack <= 1'b1;
                else e_dack <= 1'b1;
                m_owner <= 0;
                m_done  <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("mem_blk_read", mem_blk_read, (m_owner != 0) && !m_wr);
            checkOutput("mem_blk_write", mem_blk_write, (m_owner != 0) && m_wr);
            checkOutput("mem_addr", mem_addr, m_addr);
            checkOutput("mem_wblock", mem_wblock, m_wblock);
            checkOutput("i_ack", i_ack, e_iack);
            checkOutput("d_ack", d_ack, e_dack);
            checkOutput("i_rblock", i_rblock, e_irb);
            checkOutput("d_rblock", d_rblock, e_drb);
            checkOutput("busy", busy, (m_owner != 0) || m_done);
            checkOutput("drained", drained, drain && (m_owner == 0) && !m_done && !d_req);
        end
    end

    initial begin
        logic [255:0] pat_a;
        logic [255:0] pat_b;
        logic [255:0] pat_c;
        int n;
        int icnt;
        int dcnt;
        pat_a = {32{8'hA5}};
        pat_b = {16{16'h3C96}};
        pat_c = {8{32'h1234_5678}};
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        mem_rblock      = '0;
        mem_read_valid  = 1'b0;
        mem_write_valid = 1'b0;
        tick(2);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        tick(1);

        // I-side read, minimum-ish latency with valid on the 2nd strobe cycle.
        applyStimulus(1'b1, 32'h0040_001C, 1'b0, 1'b0, '0, '0, 1'b0);
        tick(1);
        checkOutput("t1_strobe", mem_blk_read, 1'b1);
        checkOutput("t1_addr", mem_addr, 32'h0040_0000);
        tick(1);
        mem_read_valid = 1'b1;
        mem_rblock     = pat_a;
        tick(1);
        checkOutput("t1_iack", i_ack, 1'b1);
        checkOutput("t1_irblock", i_rblock, pat_a);
        checkOutput("t1_strobe_drop", mem_blk_read, 1'b0);
        i_req          = 1'b0;
        mem_read_valid = 1'b0;
        tick(1);
        checkOutput("t1_idle", busy, 1'b0);

        // D-side write; a read valid must not complete it.
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h1000_0024, pat_b, 1'b0);
        tick(1);
        checkOutput("t2_wstrobe", mem_blk_write, 1'b1);
        checkOutput("t2_addr", mem_addr, 32'h1000_0020);
        checkOutput("t2_wblock", mem_wblock, pat_b);
        mem_read_valid = 1'b1;
        tick(1);
        checkOutput("t2_ignore_rvalid", d_ack, 1'b0);
        mem_read_valid  = 1'b0;
        mem_write_valid = 1'b1;
        tick(1);
        checkOutput("t2_dack", d_ack, 1'b1);
        checkOutput("t2_drblock", d_rblock, 256'h0);
        d_req           = 1'b0;
        mem_write_valid = 1'b0;
        tick(1);

        // Both sides requesting continuously: D,D,D,I repeating.
        pulseReset();
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, '0, 1'b0);
        mem_read_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            tick(1);
            if (i_ack) got_order[n++] = 1;
            else if (d_ack) got_order[n++] = 2;
        end
        checkOutput("t3_ack_count", n, 8);
        for (int k = 0; k < n; k++) checkOutput($sformatf("t3_order%0d", k), got_order[k], exp_order[k]);
        i_req = 1'b0;
        d_req = 1'b0;
        tick(4);

        // Drain: only D served, I waits; drained once D stops.
        applyStimulus(1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_0400, '0, 1'b1);
        icnt = 0;
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (i_ack) icnt++;
            if (d_ack) dcnt++;
        end
        checkOutput("t4_no_iack", icnt, 0);
        checkOutput("t4_d_served", dcnt >= 3, 1'b1);
        for (int c = 0; c < 10 && !d_ack; c++) tick(1);
        checkOutput("t4_dack_seen", d_ack, 1'b1);
        d_req = 1'b0;
        tick(1);
        checkOutput("t4_drained", drained, 1'b1);
        checkOutput("t4_idle", busy, 1'b0);
        drain = 1'b0;
        tick(1);
        checkOutput("t4_i_granted", mem_blk_read, 1'b1);
        tick(1);
        checkOutput("t4_iack", i_ack, 1'b1);
        i_req          = 1'b0;
        mem_read_valid = 1'b0;
        tick(1);

        // Reset in the middle of a D read.
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h3000_0008, '0, 1'b0);
        tick(1);
        checkOutput("t5_strobe", mem_blk_read, 1'b1);
        tick(1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_strobe_drop", mem_blk_read, 1'b0);
        checkOutput("t5_busy_drop", busy, 1'b0);
        mem_read_valid = 1'b1;
        tick(1);
        rst_n          = 1'b1;
        mem_read_valid = 1'b0;
        checkOutput("t5_no_dack", d_ack, 1'b0);
        tick(1);
        checkOutput("t5_regrant", mem_blk_read, 1'b1);
        checkOutput("t5_regrant_ack", d_ack, 1'b0);
        mem_read_valid = 1'b1;
        mem_rblock     = pat_c;
        tick(1);
        checkOutput("t5_dack", d_ack, 1'b1);
        checkOutput("t5_drblock", d_rblock, pat_c);
        d_req          = 1'b0;
        mem_read_valid = 1'b0;
        tick(1);

        // Address changes after grant must not reach memory.
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h2000_0047, '0, 1'b0);
        tick(1);
        checkOutput("t6_addr", mem_addr, 32'h2000_0040);
        d_addr = 32'hFFFF_FFFF;
        tick(2);
        checkOutput("t6_addr_held", mem_addr, 32'h2000_0040);
        mem_read_valid = 1'b1;
        tick(1);
        checkOutput("t6_dack", d_ack, 1'b1);
        d_req          = 1'b0;
        mem_read_valid = 1'b0;
        tick(1);

        // Randomized traffic; requesters hold req until the expected ack.
        for (int c = 0; c < 1500; c++) begin
            if (!i_req || e_iack) begin
                i_req  = ($urandom_range(0, 2) == 0);
                i_addr = $urandom();
            end
            if (!d_req || e_dack) begin
                d_req    = ($urandom_range(0, 2) != 0);
                d_we     = $urandom_range(0, 1);
                d_addr   = $urandom();
                d_wblock = randBlock();
            end
            if ($urandom_range(0, 19) == 0) drain = ~drain;
            mem_rblock      = randBlock();
            mem_read_valid  = ($urandom_range(0, 9) < 4);
            mem_write_valid = ($urandom_range(0, 9) < 4);
            tick(1);
        end
        i_req           = 1'b0;
        d_req           = 1'b0;
        drain           = 1'b0;
        mem_read_valid  = 1'b1;
        mem_write_valid = 1'b1;
        tick(4);
        checkOutput("final_idle", busy, 1'b0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blk_mem_arbiter.md
Name: blk_mem_arbiter

Overview:
- Arbitrates the single block-transfer port of main memory between the instruction-side block read requester (iBlkRead path) and the data-side block read/write requester (dBlkRead/dBlkWrite path).
- Latches one request at a time, drives the memory strobes until the memory reports valid, then returns data and a one-cycle ack to the winner.
- D-side has priority, with anti-starvation for I-side. A drain input supports SYS flush sequencing.

Parameters:
- ADDR_W, 32, address width.
- BLOCK_W, 256, cache block width in bits.
- OFFSET_BITS, 5, low address bits cleared to block-align (32-byte block).
- STARVE_LIMIT, 3, consecutive D grants while I waits before I is forced to win.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- i_req  in  1  I-side block read request, level, held until i_ack.
- i_addr  in  ADDR_W  I-side block address.
- i_rblock  out  BLOCK_W  I-side returned block, valid with i_ack.
- i_ack  out  1  one-cycle completion pulse to I-side.
- d_req  in  1  D-side request, level, held until d_ack.
- d_we  in  1  1 = block write, 0 = block read.
- d_addr  in  ADDR_W  D-side block address.
- d_wblock  in  BLOCK_W  D-side write block.
- d_rblock  out  BLOCK_W  D-side returned block, valid with d_ack when d_we=0.
- d_ack  out  1  one-cycle completion pulse to D-side.
- drain  in  1  1 = grant no new I requests (SYS flush in progress).
- mem_addr  out  ADDR_W  block-aligned address to memory.
- mem_blk_read  out  1  block read strobe.
- mem_blk_write  out  1  block write strobe.
- mem_wblock  out  BLOCK_W  write block to memory.
- mem_rblock  in  BLOCK_W  block read from memory.
- mem_read_valid  in  1  memory read completed this cycle.
- mem_write_valid  in  1  memory write completed this cycle.
- busy  out  1  state != IDLE.
- drained  out  1  drain=1, state IDLE, d_req=0.

Behaviour:
- Reset (RESET=0, async): state IDLE, starve_cnt=0. All outputs 0, including both rblock registers, mem_addr and mem_wblock. A transfer in flight is abandoned and strobes drop immediately. After reset, no ack is issued for the abandoned request; the requester must re-request.
- States: IDLE, I_RD, D_RD, D_WR, DONE.
- IDLE arbitration, evaluated each cycle:
  - i_eligible = i_req & ~drain.
  - Both d_req and i_eligible high: I wins iff starve_cnt >= STARVE_LIMIT, else D wins.
  - Only one eligible: that one wins. None: stay IDLE.
- On grant, register the following, then transition:
  - mem_addr = addr with low OFFSET_BITS cleared.
  - mem_wblock = d_wblock (D write only).
  - Next state: I_RD / D_RD / D_WR.
- Strobes are registered outputs: mem_blk_read=1 in I_RD/D_RD, mem_blk_write=1 in D_WR, both 0 elsewhere. First strobe cycle is the cycle after the grant.
- Busy states hold until the matching valid is sampled high; mem_addr and mem_wblock are stable throughout.
  - I_RD/D_RD complete only on mem_read_valid.
  - D_WR completes only on mem_write_valid.
  - A non-matching valid, or any valid in IDLE/DONE, is ignored.
- Completion (at the clock edge where the matching valid is sampled):
  - Read: mem_rblock captured into i_rblock or d_rblock.
  - Ack: i_ack or d_ack = 1 for exactly the next cycle.
  - Strobes drop in that same cycle; state moves to DONE.
- DONE lasts one cycle and ignores requests, which lets the requester drop req. Then IDLE.
- Minimum latency: req high at cycle 0 in IDLE, strobe at cycle 1, valid at cycle 1, ack at cycle 2, next grant evaluated at cycle 3.
- rblock registers hold their value until the next completed read for that side.
- Starvation counter (2+ bits, saturating at STARVE_LIMIT):
  - Increments on each D grant made while i_eligible=1.
  - Clears on any I grant.
  - Unchanged otherwise, including while drain is high.
- Request fields are sampled only at grant; changes after grant are ignored.
- drain rising mid I transfer: that transfer completes normally; only new I grants are blocked.

Decomposition:
- Shared package blk_mem_pkg:
  - state enum (IDLE, I_RD, D_RD, D_WR, DONE);
  - BLOCK_W and OFFSET_BITS defaults;
  - block-align function.
- One sub-module is natural: blk_arb_priority, the combinational winner select plus saturating starve counter. The FSM and datapath registers stay in the top.

Test Plan:
- Reset, then i_req=1, i_addr=0x0040_001C, no d_req. Expect mem_blk_read=1 with mem_addr=0x0040_0000 next cycle. Valid two cycles later with mem_rblock=0xA5.. pattern gives i_ack one cycle with i_rblock equal to the pattern. DONE, then IDLE.
- d_req=1, d_we=1, d_addr=0x1000_0024, d_wblock=pattern. Expect mem_blk_write=1, mem_addr=0x1000_0020. A mem_read_valid pulse is ignored. mem_write_valid completes with d_ack=1 and d_rblock unchanged.
- i_req and d_req held continuously, memory valid after 1 cycle. Expect grant order D,D,D,I,D,D,D,I; starve_cnt clears after each I.
- drain=1 with i_req and d_req. Expect only D served, i_ack never asserted, and drained=1 once d_req drops. Then drain=0: I served next.
- RESET pulled low mid D_RD. Expect strobes 0 immediately, no d_ack, state IDLE. After release, a re-requested read completes normally.
- Requester changes d_addr after grant. Expect mem_addr to keep the originally latched aligned address until completion.
